if_stage_pc: RTL and testbench
==============================

// Module: if_stage_pc
// PURPOSE
//   Fetch-stage PC register plus IF/ID pipeline register of the 5-stage miniRV pipeline.
//   Consumes the EX-stage redirect (npc_op/npc_bj) and the hazard-unit stall.
//   Drives the instruction ROM address, latches the fetched instruction into IF/ID,
//   and squashes wrong-path instructions after a taken branch or jump.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded by reset (word aligned)
//   NOP_INST  32'h0000_0013  bubble encoding (addi x0,x0,0) written on squash
//   CNT_W     32             perf-counter width (only with FETCH_PERF_CNT_EN)
// PORTS
//   cpu_clk      in   1      single clock; all state updates on rising edge
//   cpu_rst      in   1      synchronous, active-high reset
//   stall        in   1      load-use stall from hazard unit: hold PC and IF/ID
//   npc_op       in   1      EX-stage redirect request (taken branch / jal / jalr)
//   npc_bj       in   32     EX-stage redirect target
//   irom_adr     out  32     current PC to IROM (combinational read, same cycle)
//   irom_inst    in   32     instruction at irom_adr
//   id_pc        out  32     IF/ID: PC of latched instruction
//   id_pc4       out  32     IF/ID: id_pc + 4
//   id_inst      out  32     IF/ID: latched instruction
//   id_valid     out  1      IF/ID: 1 = real instruction, 0 = bubble
//   flush_id_ex  out  1      comb: = npc_op; tells ID/EX register to insert a bubble
//   fetch_cnt    out  CNT_W  [macro] instructions latched into IF/ID
//   flush_cnt    out  CNT_W  [macro] redirects taken
//   stall_cnt    out  CNT_W  [macro] stall cycles honoured
// BEHAVIOUR
//   - irom_adr = pc; pc[1:0] always 2'b00 (npc_bj[1:0] discarded on load).
//   - Reset (sync, high): pc<=RESET_PC; id_pc<=0; id_pc4<=0; id_inst<=NOP_INST; id_valid<=0.
//     Reset overrides stall and npc_op in the same cycle; reset mid-stream discards all state.
//   - Per-edge priority: cpu_rst > npc_op > stall > normal advance.
//   - Redirect (npc_op=1): pc<={npc_bj[31:2],2'b00}; IF/ID<=bubble (inst=NOP_INST,
//     valid=0, pc/pc4 hold). Redirect wins over simultaneous stall (stalled ID instr is wrong-path).
//   - Stall (npc_op=0, stall=1): pc and all IF/ID fields hold their values.
//   - Normal: pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); id_pc<=pc; id_pc4<=pc+4;
//     id_inst<=irom_inst; id_valid<=1.
//   - Latency: instruction at PC p appears on id_* one edge after p is on irom_adr.
//   - Redirect penalty: 2 squashed slots (IF/ID via bubble, ID/EX via flush_id_ex); target
//     instruction on id_* one edge after the redirect edge.
//   - flush_id_ex is purely combinational from npc_op; not registered, forced 0 during cpu_rst.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: fetch_cnt/flush_cnt/stall_cnt ports and registers exist;
//     reset to 0; fetch_cnt +1 per normal advance, flush_cnt +1 per redirect edge,
//     stall_cnt +1 per honoured stall edge (not when redirect wins); all saturate at all-ones.
//   Undefined: the three ports and their logic are absent; all other behaviour identical.
// TESTING
//   1. Reset 3 cycles, release, IROM[0..3]=I0..I3 -> irom_adr 0,4,8,C; id_inst I0 after 1st edge, id_valid=1.
//   2. Stall=1 for 2 cycles at pc=8 -> pc stays 8, id_pc stays 4, id_inst stays I1; resumes at 8.
//   3. npc_op=1, npc_bj=32'h0000_0102 at pc=C -> next pc=0x100, id_valid=0, id_inst=NOP_INST,
//      flush_id_ex=1 that cycle; next edge id_pc=0x100, id_valid=1.
//   4. npc_op=1 and stall=1 same cycle, npc_bj=0x40 -> pc=0x40, IF/ID bubble; stall ignored.
//   5. pc=32'hFFFF_FFFC normal advance -> pc=0, id_pc=FFFF_FFFC, id_pc4=0.
//   6. cpu_rst=1 together with npc_op=1 mid-run -> pc=RESET_PC, id_valid=0, flush_id_ex=0;
//      with FETCH_PERF_CNT_EN, after 5 fetches/1 flush/2 stalls counters read 5/1/2, 0 after reset.

Source files
------------

// File: rtl/if_stage_pc.sv
// Fetch-stage PC register and IF/ID pipeline register for the miniRV 5-stage pipeline.
// Optional perf counters (fetch/flush/stall) are built when FETCH_PERF_CNT_EN is defined.
module if_stage_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          CNT_W    = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             stall,
  input  logic             npc_op,
  input  logic [31:0]      npc_bj,
  output logic [31:0]      irom_adr,
  input  logic [31:0]      irom_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc4,
  output logic [31:0]      id_inst,
  output logic             id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             flush_id_ex
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4    = pc + 32'd4;
  assign irom_adr    = pc;
  assign flush_id_ex = npc_op & ~cpu_rst;

  // Redirect beats stall: the stalled ID instruction is on the wrong path anyway.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc       <= {RESET_PC[31:2], 2'b00};
      id_pc    <= 32'd0;
      id_pc4   <= 32'd0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (npc_op) begin
      pc       <= {npc_bj[31:2], 2'b00};
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= pc_plus4;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_inst  <= irom_inst;
      id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else if (npc_op) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_pc.sv
// Scoreboard bench for if_stage_pc: directed scenarios then random stimulus vs a reference model.
module tb_if_stage_pc;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          CNT_W    = 32;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst, stall, npc_op;
  logic [31:0] npc_bj, irom_adr, irom_inst, id_pc, id_pc4, id_inst;
  logic        id_valid, flush_id_ex;
`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt, flush_cnt, stall_cnt;
`endif

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
  endfunction

  assign irom_inst = rom_word(irom_adr);

  if_stage_pc #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .stall(stall), .npc_op(npc_op), .npc_bj(npc_bj),
    .irom_adr(irom_adr), .irom_inst(irom_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_inst(id_inst), .id_valid(id_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt),
`endif
    .flush_id_ex(flush_id_ex)
  );

  typedef struct {
    logic [31:0] pc, id_pc, id_pc4, id_inst;
    logic        id_valid, flush;
    logic [CNT_W-1:0] fcnt, rcnt, scnt;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state: architectural view of the fetch stage after each edge.
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
  logic        m_id_valid;
  logic [CNT_W-1:0] m_fcnt, m_rcnt, m_scnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] ones;
    ones = '1;
    return (v == ones) ? v : v + 1;
  endfunction

  task automatic step(input logic rst, input logic stl, input logic op, input logic [31:0] bj);
    exp_t e;
    cpu_rst = rst; stall = stl; npc_op = op; npc_bj = bj;
    if (rst) begin
      m_pc = RESET_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = NOP_INST; m_id_valid = 0;
      m_fcnt = 0; m_rcnt = 0; m_scnt = 0;
    end else if (op) begin
      m_pc = bj & 32'hFFFF_FFFC;
      m_id_inst = NOP_INST; m_id_valid = 0;
      m_rcnt = sat_inc(m_rcnt);
    end else if (stl) begin
      m_scnt = sat_inc(m_scnt);
    end else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = rom_word(m_pc); m_id_valid = 1;
      m_pc = m_pc + 4;
      m_fcnt = sat_inc(m_fcnt);
    end
    e.pc = m_pc; e.id_pc = m_id_pc; e.id_pc4 = m_id_pc4; e.id_inst = m_id_inst;
    e.id_valid = m_id_valid; e.flush = op & ~rst;
    e.fcnt = m_fcnt; e.rcnt = m_rcnt; e.scnt = m_scnt;
    exp_q.push_back(e);
    @(negedge cpu_clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, vectors, act, req);
    end
  endtask

  // Monitor: inputs applied before the last edge are still held here, so flush_id_ex
  // reflects the same cycle as the expectation record.
  always @(negedge cpu_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      chk("irom_adr", irom_adr, e.pc);
      chk("id_pc", id_pc, e.id_pc);
      chk("id_pc4", id_pc4, e.id_pc4);
      chk("id_inst", id_inst, e.id_inst);
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.id_valid});
      chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.flush});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", 32'(fetch_cnt), 32'(e.fcnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.rcnt));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
`endif
    end
  end

  initial begin
    m_pc = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 0; m_id_valid = 0;
    m_fcnt = 0; m_rcnt = 0; m_scnt = 0;
    // reset, fetch 0/4, stall at pc=8, resume, redirect to 0x102 -> 0x100, fetch two
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0102);
    repeat (2) step(0, 0, 0, 0);
    // reset together with redirect mid-stream
    step(1, 0, 1, 32'h0000_0200);
    repeat (2) step(0, 0, 0, 0);
    // redirect with simultaneous stall
    step(0, 1, 1, 32'h0000_0040);
    step(0, 0, 0, 0);
    // PC wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFF);
    repeat (3) step(0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(3) == 0),
           ($urandom_range(5) == 0), $urandom);
    end
    cpu_rst = 0; stall = 1; npc_op = 0;
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge cpu_clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
